// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one 16-bit {wr, addr[6:0], wdata[7:0]} frame per
// accepted command, MSB first, and captures cipo during the data byte into rdata.
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       cipo,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic            high_q, high_d;
    logic [15:0]     frame_q, frame_d;
    logic [7:0]      cap_q, cap_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            sclk_q, sclk_d;
    logic            copi_q, copi_d;
    logic            ncs_q, ncs_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        high_d  = high_q;
        frame_d = frame_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = SETUP;
                    frame_d = {wr, addr, wdata};
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    copi_d  = wr;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = 4'd15;
                    high_d  = 1'b0;
                    copi_d  = frame_q[15];
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!high_q) begin
                        high_d = 1'b1;
                        sclk_d = 1'b1;
                    end else begin
                        // End of the high phase: sample cipo just before SCLK falls.
                        high_d = 1'b0;
                        sclk_d = 1'b0;
                        if (!bit_q[3]) cap_d = {cap_q[6:0], cipo};
                        bit_d = bit_q - 4'd1;
                        if (bit_q == 4'd0) state_d = HOLD;
                        else               copi_d  = frame_q[bit_q - 4'd1];
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = cap_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd15;
            high_q  <= 1'b0;
            frame_q <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            high_q  <= high_d;
            frame_q <= frame_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign copi  = copi_q;
    assign ncs   = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a default-timing instance and a fast-timing instance,
// a cycle-timing model checked every cycle, a peripheral model, and directed scenarios.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_w, wr_w;
    logic [6:0] addr_w  [2];
    logic [7:0] wdata_w [2];
    logic [1:0] cipo_w = 2'b00;
    logic [15:0] resp_w [2];

    wire [1:0] busy_w, done_w, sclk_w, copi_w, ncs_w;
    wire [7:0] rdata0, rdata1;

    spi_controller u_dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .wr(wr_w[0]), .addr(addr_w[0]),
        .wdata(wdata_w[0]), .cipo(cipo_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .rdata(rdata0), .sclk(sclk_w[0]), .copi(copi_w[0]), .ncs(ncs_w[0])
    );

    spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .wr(wr_w[1]), .addr(addr_w[1]),
        .wdata(wdata_w[1]), .cipo(cipo_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .rdata(rdata1), .sclk(sclk_w[1]), .copi(copi_w[1]), .ncs(ncs_w[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string name, input int inst, input logic [15:0] got,
                         input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s (u%0d) cycle %0d: got %h, expected %h", name, inst, cyc, got, want);
        end
    endtask

    function automatic int p_s(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int p_d(input int i); return (i == 0) ? 4 : 2; endfunction
    function automatic int p_h(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int p_g(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int t_done(input int i);
        return 1 + p_s(i) + 32 * p_d(i) + p_h(i) + p_g(i);
    endfunction

    // Model: frame timing derived from the accept cycle with plain arithmetic.
    bit          m_valid [2] = '{0, 0};
    bit          m_act   [2] = '{0, 0};
    int          m_acc   [2];
    logic [15:0] m_frame [2];
    logic [15:0] m_resp  [2];
    logic [7:0]  m_rd    [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i]   = 0;
                m_rd[i]    = 8'h00;
                m_valid[i] = 1;
            end else begin
                bit idle_now;
                idle_now = !m_act[i] || (cyc - m_acc[i]) >= t_done(i);
                if (idle_now && start_w[i]) begin
                    m_acc[i]   = cyc;
                    m_act[i]   = 1;
                    m_frame[i] = {wr_w[i], addr_w[i], wdata_w[i]};
                    m_resp[i]  = resp_w[i];
                end else if (idle_now) begin
                    m_act[i] = 0;
                end
                if (m_act[i] && (cyc + 1 - m_acc[i]) == t_done(i)) m_rd[i] = m_resp[i][7:0];
            end
        end
        cyc++;
    end

    task automatic compare_outputs(input int i);
        int t, s, d, h, u, k;
        logic e_ncs, e_sclk, e_copi, e_busy, e_done;
        e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_act[i]) begin
            t = cyc - m_acc[i];
            s = p_s(i); d = p_d(i); h = p_h(i);
            u = t - 1 - s;
            e_busy = (t >= 1) && (t < t_done(i));
            e_done = (t == t_done(i));
            e_ncs  = !((t >= 1) && (t <= s + 32 * d + h));
            e_sclk = (u >= 0) && (u < 32 * d) && (((u / d) % 2) == 1);
            if (t >= 1 && t <= s) begin
                e_copi = m_frame[i][15];
            end else if (t > s && t <= s + 32 * d + h) begin
                k = u / (2 * d);
                if (k > 15) k = 15;
                e_copi = m_frame[i][15 - k];
            end
        end
        check("ncs",   i, ncs_w[i],  e_ncs);
        check("sclk",  i, sclk_w[i], e_sclk);
        check("copi",  i, copi_w[i], e_copi);
        check("busy",  i, busy_w[i], e_busy);
        check("done",  i, done_w[i], e_done);
        check("rdata", i, (i == 0) ? rdata0 : rdata1, m_rd[i]);
    endtask

    // Peripheral model and event log, evaluated mid-cycle.
    logic        ncs_prev  [2] = '{1'b1, 1'b1};
    logic        sclk_prev [2] = '{1'b0, 1'b0};
    int          pcnt [2] = '{0, 0};
    logic [15:0] pcap [2];
    int          fall_cyc [2], rise_cyc [2], done_cyc [2], first_rise [2], last_fall [2];
    int          done_cnt [2] = '{0, 0};
    logic [15:0] frame_seen [2];
    int          edges_seen [2];
    logic [7:0]  rdata_done [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) compare_outputs(i);
            if (ncs_prev[i] && !ncs_w[i]) begin
                fall_cyc[i] = cyc;
                pcnt[i]     = 0;
                pcap[i]     = 16'h0000;
                cipo_w[i]   = resp_w[i][15];
            end
            if (!ncs_prev[i] && ncs_w[i]) begin
                rise_cyc[i]   = cyc;
                frame_seen[i] = pcap[i];
                edges_seen[i] = pcnt[i];
            end
            if (!ncs_w[i] && !sclk_prev[i] && sclk_w[i]) begin
                if (pcnt[i] == 0) first_rise[i] = cyc;
                pcap[i] = {pcap[i][14:0], copi_w[i]};
                pcnt[i]++;
            end
            if (sclk_prev[i] && !sclk_w[i]) begin
                last_fall[i] = cyc;
                if (!ncs_w[i] && pcnt[i] < 16) cipo_w[i] = resp_w[i][15 - pcnt[i]];
            end
            if (done_w[i] === 1'b1) begin
                done_cyc[i]   = cyc;
                done_cnt[i]++;
                rdata_done[i] = (i == 0) ? rdata0 : rdata1;
            end
            ncs_prev[i]  = ncs_w[i];
            sclk_prev[i] = sclk_w[i];
        end
    end

    task automatic to_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input int i, input logic w, input logic [6:0] a, input logic [7:0] d,
                          input logic [15:0] resp, output int acc_o);
        wr_w[i]    = w;
        addr_w[i]  = a;
        wdata_w[i] = d;
        resp_w[i]  = resp;
        start_w[i] = 1'b1;
        acc_o      = cyc;
        to_cycle(cyc + 1);
        start_w[i] = 1'b0;
    endtask

    initial begin
        int acc, dc;
        rst = 1'b1;
        start_w = 2'b11;
        wr_w = 2'b11;
        addr_w  = '{7'h7F, 7'h7F};
        wdata_w = '{8'hFF, 8'hFF};
        resp_w  = '{16'h0000, 16'h0000};

        // Reset while start is asserted: idle outputs, nothing launched.
        to_cycle(3);
        check("rst ncs",   0, ncs_w,  2'b11);
        check("rst sclk",  0, sclk_w, 2'b00);
        check("rst copi",  0, copi_w, 2'b00);
        check("rst busy",  0, busy_w, 2'b00);
        check("rst done",  0, done_w, 2'b00);
        check("rst rdata", 0, rdata0, 8'h00);
        check("rst rdata", 1, rdata1, 8'h00);
        rst = 1'b0;
        start_w = 2'b00;
        to_cycle(cyc + 3);
        check("no frame busy", 0, busy_w, 2'b00);
        check("no frame ncs",  0, ncs_w,  2'b11);

        // Write with default timing.
        dc = done_cnt[0];
        launch(0, 1'b1, 7'h00, 8'hA5, 16'h0000, acc);
        to_cycle(acc + 140);
        check("wr ncs fall",   0, fall_cyc[0] - acc, 1);
        check("wr ncs rise",   0, rise_cyc[0] - acc, 133);
        check("wr sclk first", 0, first_rise[0] - acc, 7);
        check("wr sclk last",  0, last_fall[0] - acc, 131);
        check("wr done cyc",   0, done_cyc[0] - acc, 135);
        check("wr done once",  0, done_cnt[0] - dc, 1);
        check("wr frame",      0, frame_seen[0], 16'h80A5);
        check("wr edges",      0, edges_seen[0], 16);

        // Read: data byte sent as-is, cipo returns 3C after a byte of 1s.
        launch(0, 1'b0, 7'h03, 8'h5A, 16'hFF3C, acc);
        to_cycle(acc + 140);
        check("rd frame",      0, frame_seen[0], 16'h035A);
        check("rd rdata@done", 0, rdata_done[0], 8'h3C);
        check("rd rdata held", 0, rdata0, 8'h3C);

        // Back-to-back with start held high; inputs change mid-frame.
        dc = done_cnt[0];
        wr_w[0] = 1'b1; addr_w[0] = 7'h11; wdata_w[0] = 8'h22; resp_w[0] = 16'h00C9;
        start_w[0] = 1'b1;
        acc = cyc;
        to_cycle(acc + 60);
        wr_w[0] = 1'b0; addr_w[0] = 7'h55; wdata_w[0] = 8'h66;
        to_cycle(acc + 137);
        start_w[0] = 1'b0;
        check("b2b done1",     0, done_cyc[0] - acc, 135);
        check("b2b ncs2 fall", 0, fall_cyc[0] - acc, 136);
        check("b2b frame1",    0, frame_seen[0], 16'h9122);
        check("b2b rdata1",    0, rdata_done[0], 8'hC9);
        to_cycle(acc + 135 + 140);
        check("b2b done2",     0, done_cyc[0] - acc, 270);
        check("b2b frame2",    0, frame_seen[0], 16'h5566);
        check("b2b done cnt",  0, done_cnt[0] - dc, 2);

        // Reset mid-frame drops the command; next command runs normally.
        dc = done_cnt[0];
        launch(0, 1'b1, 7'h2A, 8'hC3, 16'h0000, acc);
        to_cycle(acc + 50);
        rst = 1'b1;
        to_cycle(acc + 51);
        rst = 1'b0;
        check("mid rst ncs",   0, ncs_w[0], 1'b1);
        check("mid rst sclk",  0, sclk_w[0], 1'b0);
        check("mid rst rdata", 0, rdata0, 8'h00);
        to_cycle(acc + 200);
        check("mid rst no done", 0, done_cnt[0] - dc, 0);
        launch(0, 1'b1, 7'h2A, 8'hC3, 16'h0000, acc);
        to_cycle(acc + 140);
        check("post rst frame", 0, frame_seen[0], 16'hAAC3);
        check("post rst done",  0, done_cyc[0] - acc, 135);

        // Minimum timing instance.
        launch(1, 1'b1, 7'h04, 8'hFF, 16'h0000, acc);
        to_cycle(acc + 75);
        check("fast frame",      1, frame_seen[1], 16'h84FF);
        check("fast sclk first", 1, first_rise[1] - acc, 4);
        check("fast sclk last",  1, last_fall[1] - acc, 66);
        check("fast ncs rise",   1, rise_cyc[1] - acc, 67);
        check("fast done",       1, done_cyc[1] - acc, 68);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
